config_frame_writer: RTL and testbench



---
 rtl/config_frame_writer.sv | 146 ++++++++++++++
 tb/tb_config_frame_writer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/config_frame_writer.sv
// Loads NumberOfRows words into FrameData, then pulses one FrameStrobe bit the cycle after the last word; a frame takes NumberOfRows+3 cycles.
// s_ready drops for the STROBE and HOLD cycles only. Defining FRAME_WRITER_PARITY_EN checks the data parity against header bit 30.
module config_frame_writer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfRows    = 9,
    parameter int NumberOfCols    = 23
) (
    input  logic                                      UserCLK,
    input  logic                                      rst,
    input  logic [31:0]                               s_data,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0]   FrameStrobe,
    output logic                                      busy,
    output logic                                      err,
    output logic [15:0]                               frame_count
);
    localparam int RowW       = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int NumStrobes = NumberOfCols * MaxFramesPerCol;
    localparam int StrW       = (NumStrobes > 1) ? $clog2(NumStrobes) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, DISCARD, STROBE, HOLD} state_t;

    state_t                                  r_state;
    logic [RowW-1:0]                         r_row;
    logic [7:0]                              r_col;
    logic [4:0]                              r_frame;
    logic                                    r_ready;
    logic                                    r_busy;
    logic                                    r_err;
    logic [15:0]                             r_frame_count;
    logic [NumberOfRows*FrameBitsPerRow-1:0] r_frame_data;
    logic [NumStrobes-1:0]                   r_strobe;

    logic            w_xfer;
    logic            w_last_row;
    logic            w_hdr_bad;
    logic            w_par_ok;
    logic [StrW-1:0] w_strobe_idx;

    assign w_xfer       = s_valid & r_ready;
    assign w_last_row   = (r_row == RowW'(NumberOfRows - 1));
    assign w_hdr_bad    = (int'(s_data[15:8]) >= NumberOfCols) || (int'(s_data[4:0]) >= MaxFramesPerCol);
    assign w_strobe_idx = StrW'(int'(r_col) * MaxFramesPerCol + int'(r_frame));

`ifdef FRAME_WRITER_PARITY_EN
    logic r_par_exp;
    logic r_par_acc;

    // The last word's parity is folded in combinationally so the verdict is ready at the STROBE transition.
    assign w_par_ok = ((r_par_acc ^ (^s_data)) == r_par_exp);

    always_ff @(posedge UserCLK or negedge rst) begin
        if (!rst) begin
            r_par_exp <= 1'b0;
            r_par_acc <= 1'b0;
        end else if (w_xfer) begin
            if (r_state == IDLE && s_data[31]) begin
                r_par_exp <= s_data[30];
                r_par_acc <= 1'b0;
            end else if (r_state == LOAD) begin
                r_par_acc <= r_par_acc ^ (^s_data);
            end
        end
    end
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge UserCLK or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_frame       <= '0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_frame_count <= '0;
            r_frame_data  <= '0;
            r_strobe      <= '0;
        end else begin
            r_strobe <= '0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    // Words without bit 31 are padding and are simply swallowed.
                    if (w_xfer && s_data[31]) begin
                        r_row   <= '0;
                        r_col   <= s_data[15:8];
                        r_frame <= s_data[4:0];
                        r_busy  <= 1'b1;
                        if (w_hdr_bad) begin
                            r_err   <= 1'b1;
                            r_state <= DISCARD;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (w_xfer) begin
                        r_frame_data[int'(r_row)*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                        r_row <= r_row + 1'b1;
                        if (w_last_row) begin
                            r_state <= STROBE;
                            r_ready <= 1'b0;
                            if (w_par_ok) begin
                                r_strobe[w_strobe_idx] <= 1'b1;
                                r_frame_count          <= r_frame_count + 16'd1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (w_xfer) begin
                        r_row <= r_row + 1'b1;
                        if (w_last_row) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                STROBE: r_state <= HOLD;
                HOLD: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready     = r_ready;
    assign busy        = r_busy;
    assign err         = r_err;
    assign frame_count = r_frame_count;
    assign FrameData   = r_frame_data;
    assign FrameStrobe = r_strobe;

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer: frame load/strobe timing, stalls, bad header, padding, mid-frame reset, optional parity.
module tb_config_frame_writer;
    localparam int ROWS = 9;
    localparam int COLS = 23;
    localparam int FPC  = 20;

    logic        UserCLK = 1'b0;
    logic        rst     = 1'b0;
    logic [31:0] s_data  = '0;
    logic        s_valid = 1'b0;

    wire                   s_ready;
    wire [ROWS*32-1:0]     FrameData;
    wire [COLS*FPC-1:0]    FrameStrobe;
    wire                   busy;
    wire                   err;
    wire [15:0]            frame_count;

    int n_vec = 0;
    int n_bad = 0;
    int strobe_cycles = 0;
    int multi_hot = 0;
    int exp_fc = 0;
    int snap;

    always #5 UserCLK = ~UserCLK;

    config_frame_writer #(
        .FrameBitsPerRow(32),
        .MaxFramesPerCol(FPC),
        .NumberOfRows(ROWS),
        .NumberOfCols(COLS)
    ) dut (
        .UserCLK(UserCLK),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .FrameData(FrameData),
        .FrameStrobe(FrameStrobe),
        .busy(busy),
        .err(err),
        .frame_count(frame_count)
    );

    always @(negedge UserCLK) begin
        if ($countones(FrameStrobe) != 0) begin
            strobe_cycles++;
            if ($countones(FrameStrobe) > 1) multi_hot++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        @(negedge UserCLK);
        s_data  = d;
        s_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = s_ready;
            @(posedge UserCLK);
            if (!acc) @(negedge UserCLK);
            n++;
        end
        chk("handshake", acc, 1'b1);
        #1 s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] mul, input bit gap);
        send_word(hdr);
        for (int k = 0; k < ROWS; k++) begin
            if (gap) @(posedge UserCLK);
            send_word(32'(k + 1) * mul);
        end
    endtask

    task automatic check_rows(input logic [31:0] mul);
        for (int k = 0; k < ROWS; k++)
            chk($sformatf("row%0d", k), FrameData[k*32 +: 32], 32'(k + 1) * mul);
    endtask

    // Called right after the last data word's accepting edge.
    task automatic strobe_window(input bit fire, input int idx);
        @(negedge UserCLK);
        chk("stb_ones", $countones(FrameStrobe), fire ? 1 : 0);
        if (fire) chk("stb_bit", FrameStrobe[idx], 1'b1);
        chk("rdy_strobe", s_ready, 1'b0);
        chk("busy_strobe", busy, 1'b1);
        @(negedge UserCLK);
        chk("stb_hold", $countones(FrameStrobe), 0);
        chk("rdy_hold", s_ready, 1'b0);
        @(negedge UserCLK);
        chk("rdy_idle", s_ready, 1'b1);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge UserCLK);
        chk("rst_data", (FrameData == '0), 1'b1);
        chk("rst_strobe", $countones(FrameStrobe), 0);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_fc", frame_count, 16'h0);
        rst = 1'b1;
        @(posedge UserCLK);
        #1 chk("ready_after_rst", s_ready, 1'b1);

        // Basic frame: col 3, frame 5 -> strobe bit 65
        send_frame(32'h8000_0305, 32'h1111_1111, 1'b0);
        exp_fc++;
        strobe_window(1'b1, 65);
        check_rows(32'h1111_1111);
        chk("fc_a", frame_count, 16'(exp_fc));

        // Same frame with s_valid toggled
        send_frame(32'h8000_0305, 32'h1111_1111, 1'b1);
        exp_fc++;
        strobe_window(1'b1, 65);
        check_rows(32'h1111_1111);
        chk("fc_toggle", frame_count, 16'(exp_fc));

        // Out-of-range column is discarded
        snap = strobe_cycles;
        send_frame(32'h8000_1700, 32'h00DE_0001, 1'b0);
        @(negedge UserCLK);
        chk("disc_err", err, 1'b1);
        chk("disc_busy", busy, 1'b0);
        chk("disc_ready", s_ready, 1'b1);
        chk("disc_nostrobe", strobe_cycles, snap);
        chk("disc_fc", frame_count, 16'(exp_fc));
        check_rows(32'h1111_1111);

        // Highest column/frame: col 22, frame 19 -> bit 459
        send_frame(32'h8000_1613, 32'h0100_0001, 1'b0);
        exp_fc++;
        strobe_window(1'b1, 459);
        check_rows(32'h0100_0001);
        chk("fc_edge", frame_count, 16'(exp_fc));

        // Padding words in IDLE
        snap = strobe_cycles;
        for (int p = 0; p < 3; p++) begin
            send_word(32'h0000_0000);
            @(negedge UserCLK);
            chk("pad_busy", busy, 1'b0);
        end
        chk("pad_nostrobe", strobe_cycles, snap);
        send_frame(32'h8000_0101, 32'h0101_0101, 1'b0);
        exp_fc++;
        strobe_window(1'b1, 21);
        check_rows(32'h0101_0101);
        chk("fc_pad", frame_count, 16'(exp_fc));

        // Reset mid-frame after 4 data words
        snap = strobe_cycles;
        send_word(32'h8000_0204);
        for (int k = 0; k < 4; k++) send_word(32'(k + 1) * 32'h1111_1111);
        @(negedge UserCLK);
        rst = 1'b0;
        #1;
        chk("mid_data", (FrameData == '0), 1'b1);
        chk("mid_ready", s_ready, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_err", err, 1'b0);
        chk("mid_fc", frame_count, 16'h0);
        repeat (3) @(posedge UserCLK);
        @(negedge UserCLK);
        rst = 1'b1;
        repeat (10) @(posedge UserCLK);
        #1;
        chk("mid_nostrobe", strobe_cycles, snap);
        chk("mid_fc_after", frame_count, 16'h0);
        exp_fc = 0;

        send_frame(32'h8000_0305, 32'h1111_1111, 1'b0);
        exp_fc++;
        strobe_window(1'b1, 65);
        check_rows(32'h1111_1111);
        chk("fc_recover", frame_count, 16'(exp_fc));
        chk("err_recover", err, 1'b0);

`ifdef FRAME_WRITER_PARITY_EN
        // Data XOR = 1 against header parity 0, then 1
        send_word(32'h8000_0305);
        for (int k = 0; k < ROWS; k++) send_word((k == ROWS - 1) ? 32'h1 : 32'h0);
        strobe_window(1'b0, 0);
        chk("par_err", err, 1'b1);
        chk("par_fc", frame_count, 16'(exp_fc));
        chk("par_row8", FrameData[(ROWS-1)*32 +: 32], 32'h1);
        send_word(32'hC000_0305);
        for (int k = 0; k < ROWS; k++) send_word((k == ROWS - 1) ? 32'h1 : 32'h0);
        exp_fc++;
        strobe_window(1'b1, 65);
        chk("par_ok_fc", frame_count, 16'(exp_fc));
`endif

        chk("one_hot", multi_hot, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
